// File: rtl/dilated_tap_buffer_pkg.sv
// Shared constants, sample type and FSM encoding for the dilated tap buffer.
package dilated_tap_buffer_pkg;
    localparam int unsigned W        = 16;
    localparam int unsigned D        = 8;
    localparam int unsigned NUM_TAPS = 4;
    localparam int unsigned SAMPLE_W = D * W;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    // Distance in samples between tap j and the newest sample.
    function automatic int unsigned tap_lag(input int unsigned j, input int unsigned dil);
        return (NUM_TAPS - 1 - j) * dil;
    endfunction
endpackage

// File: rtl/dilated_tap_buffer_if.sv
// Sample-in / taps-out bundle between the producer and the tap buffer.
interface dilated_tap_buffer_if;
    import dilated_tap_buffer_pkg::*;

    sample_t packed_in;
    logic    in_v;
    logic    busy;
    sample_t packed_a0;
    sample_t packed_a1;
    sample_t packed_a2;
    sample_t packed_a3;
    logic    out_v;
    logic    overrun;

    modport master (
        output packed_in, in_v,
        input  busy, packed_a0, packed_a1, packed_a2, packed_a3, out_v, overrun
    );

    modport slave (
        input  packed_in, in_v,
        output busy, packed_a0, packed_a1, packed_a2, packed_a3, out_v, overrun
    );
endinterface

// File: rtl/dilated_tap_buffer_circular_sample_buffer.sv
// Circular sample store: one write port, four registered read ports with per-port zero force.
module circular_sample_buffer
    import dilated_tap_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr [NUM_TAPS],
    input  logic [NUM_TAPS-1:0]        zero,
    output logic [WIDTH-1:0]           rdata [NUM_TAPS]
);
    logic [WIDTH-1:0] mem_q   [DEPTH];
    logic [WIDTH-1:0] rdata_q [NUM_TAPS];
    logic [WIDTH-1:0] rdata_d [NUM_TAPS];

    // Storage is deliberately unreset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            for (int j = 0; j < int'(NUM_TAPS); j++) begin
                rdata_d[j] = zero[j] ? '0 : mem_q[raddr[j]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < int'(NUM_TAPS); j++) begin
                rdata_q[j] <= '0;
            end
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/dilated_tap_buffer.sv
// Streaming activation cache presenting four dilated time taps to conv1d.
// Optional causal zero padding during warm-up under `define TAP_ZERO_PAD_EN.
module dilated_tap_buffer
    import dilated_tap_buffer_pkg::*;
#(
    parameter int unsigned DILATION = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    dilated_tap_buffer_if.slave  bus
);
    localparam int unsigned DEPTH = 3 * DILATION + 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    state_t          state_q,    state_d;
    logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0]   fill_cnt_q, fill_cnt_d;
    logic            busy_q,     busy_d;
    logic            out_v_q,    out_v_d;
    logic            overrun_q,  overrun_d;

    logic                we;
    logic                re;
    logic                emit_ok;
    logic [AW-1:0]       raddr [NUM_TAPS];
    logic [NUM_TAPS-1:0] zero;
    logic [SAMPLE_W-1:0] rdata [NUM_TAPS];

    // Tap addresses: add DEPTH first so the modular subtraction never goes negative.
    always_comb begin
        for (int j = 0; j < int'(NUM_TAPS); j++) begin
            int unsigned lag;
            int unsigned sum;
            lag = tap_lag(32'(j), DILATION);
            sum = 32'(wr_ptr_q) + DEPTH - lag;
            if (sum >= DEPTH) begin
                sum = sum - DEPTH;
            end
            raddr[j] = AW'(sum);
`ifdef TAP_ZERO_PAD_EN
            zero[j] = (lag >= 32'(fill_cnt_q));
`else
            zero[j] = 1'b0;
`endif
        end
`ifdef TAP_ZERO_PAD_EN
        emit_ok = 1'b1;
`else
        emit_ok = (fill_cnt_q == CW'(DEPTH));
`endif
    end

    // Next-state and control.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        busy_d     = busy_q;
        out_v_d    = out_v_q;
        overrun_d  = overrun_q;
        we         = 1'b0;
        re         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_v) begin
                    we      = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_GATHER;
                    if (fill_cnt_q != CW'(DEPTH)) begin
                        fill_cnt_d = fill_cnt_q + CW'(1);
                    end
                end
            end
            ST_GATHER: begin
                re       = emit_ok;
                out_v_d  = emit_ok;
                wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
                if (bus.in_v) begin
                    overrun_d = 1'b1;
                end
                state_d  = ST_EMIT;
            end
            ST_EMIT: begin
                out_v_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                // Back-to-back accept keeps throughput at one sample per two cycles.
                if (bus.in_v) begin
                    we      = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_GATHER;
                    if (fill_cnt_q != CW'(DEPTH)) begin
                        fill_cnt_d = fill_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            busy_q     <= 1'b0;
            out_v_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            busy_q     <= busy_d;
            out_v_q    <= out_v_d;
            overrun_q  <= overrun_d;
        end
    end

    circular_sample_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (bus.packed_in),
        .re    (re),
        .raddr (raddr),
        .zero  (zero),
        .rdata (rdata)
    );

    assign bus.packed_a0 = rdata[0];
    assign bus.packed_a1 = rdata[1];
    assign bus.packed_a2 = rdata[2];
    assign bus.packed_a3 = rdata[3];
    assign bus.busy      = busy_q;
    assign bus.out_v     = out_v_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_dilated_tap_buffer.sv
// Self-checking bench: DILATION=1 and DILATION=2 instances share one stimulus stream.
module tb_dilated_tap_buffer;
    import dilated_tap_buffer_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    logic    in_v;
    sample_t drv_data;

    always #5 clk = ~clk;

    dilated_tap_buffer_if if1 ();
    dilated_tap_buffer_if if2 ();

    assign if1.in_v      = in_v;
    assign if1.packed_in = drv_data;
    assign if2.in_v      = in_v;
    assign if2.packed_in = drv_data;

    dilated_tap_buffer #(.DILATION(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    dilated_tap_buffer #(.DILATION(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: list of accepted samples since reset, held taps, sticky overrun.
    sample_t hist[$];
    sample_t exp_a [2][4];
    logic    exp_ovr;
    logic    obs_ov1;

    typedef struct {
        logic [W-1:0] lane;
        logic         exp_ov;
        logic [W-1:0] e0, e1, e2, e3;
    } vec_t;

    function automatic sample_t mk(input logic [W-1:0] lane);
        sample_t s;
        for (int c = 0; c < int'(D); c++) s[c*W +: W] = lane;
        return s;
    endfunction

    function automatic int dil_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic model_emits(input int d);
`ifdef TAP_ZERO_PAD_EN
        return (d >= 0);
`else
        return hist.size() >= 3 * dil_of(d) + 1;
`endif
    endfunction

    function automatic sample_t model_tap(input int d, input int j);
        int n   = hist.size();
        int lag = (3 - j) * dil_of(d);
        if (lag >= n) return '0;
        return hist[n - 1 - lag];
    endfunction

    function automatic sample_t get_tap(input int d, input int j);
        if (d == 0) begin
            case (j)
                0: return if1.packed_a0;
                1: return if1.packed_a1;
                2: return if1.packed_a2;
                default: return if1.packed_a3;
            endcase
        end
        case (j)
            0: return if2.packed_a0;
            1: return if2.packed_a1;
            2: return if2.packed_a2;
            default: return if2.packed_a3;
        endcase
    endfunction

    function automatic logic get_ov(input int d);
        return (d == 0) ? if1.out_v : if2.out_v;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? if1.busy : if2.busy;
    endfunction

    function automatic logic get_ovr(input int d);
        return (d == 0) ? if1.overrun : if2.overrun;
    endfunction

    task automatic chk(input string name, input logic [SAMPLE_W-1:0] act, input logic [SAMPLE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        exp_ovr = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int j = 0; j < 4; j++) exp_a[d][j] = '0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d out_v", tag, d), SAMPLE_W'(get_ov(d)), '0);
            chk($sformatf("%s d%0d busy", tag, d), SAMPLE_W'(get_busy(d)), '0);
            chk($sformatf("%s d%0d overrun", tag, d), SAMPLE_W'(get_ovr(d)), '0);
            for (int j = 0; j < 4; j++)
                chk($sformatf("%s d%0d a%0d", tag, d, j), get_tap(d, j), '0);
        end
    endtask

    // Sampled one cycle after acceptance: out_v pulse and fresh taps.
    task automatic check_emit(input string tag);
        for (int d = 0; d < 2; d++) begin
            logic e = model_emits(d);
            if (e) for (int j = 0; j < 4; j++) exp_a[d][j] = model_tap(d, j);
            chk($sformatf("%s d%0d out_v", tag, d), SAMPLE_W'(get_ov(d)), SAMPLE_W'(e));
            chk($sformatf("%s d%0d busy@g", tag, d), SAMPLE_W'(get_busy(d)), SAMPLE_W'(1));
            for (int j = 0; j < 4; j++)
                chk($sformatf("%s d%0d a%0d", tag, d, j), get_tap(d, j), exp_a[d][j]);
        end
        obs_ov1 = if1.out_v;
    endtask

    // Sampled two cycles after acceptance: pulse over, taps held.
    task automatic check_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d out_v off", tag, d), SAMPLE_W'(get_ov(d)), '0);
            chk($sformatf("%s d%0d busy off", tag, d), SAMPLE_W'(get_busy(d)), '0);
            chk($sformatf("%s d%0d overrun", tag, d), SAMPLE_W'(get_ovr(d)), SAMPLE_W'(exp_ovr));
            for (int j = 0; j < 4; j++)
                chk($sformatf("%s d%0d hold a%0d", tag, d, j), get_tap(d, j), exp_a[d][j]);
        end
    endtask

    task automatic send(input sample_t s, input string tag);
        @(negedge clk);
        drv_data = s;
        in_v     = 1'b1;
        @(negedge clk);
        in_v = 1'b0;
        hist.push_back(s);
        chk({tag, " busy d0"}, SAMPLE_W'(if1.busy), SAMPLE_W'(1));
        chk({tag, " busy d1"}, SAMPLE_W'(if2.busy), SAMPLE_W'(1));
        @(negedge clk);
        check_emit(tag);
        @(negedge clk);
        check_idle(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        in_v = 1'b0;
        model_reset();
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    vec_t    tbl [4];
    sample_t s;

    initial begin
        rst      = 1'b1;
        in_v     = 1'b0;
        drv_data = '0;
        obs_ov1  = 1'b0;
        model_reset();

`ifdef TAP_ZERO_PAD_EN
        tbl[0] = '{16'd1, 1'b1, 16'd0, 16'd0, 16'd0, 16'd1};
        tbl[1] = '{16'd2, 1'b1, 16'd0, 16'd0, 16'd1, 16'd2};
        tbl[2] = '{16'd3, 1'b1, 16'd0, 16'd1, 16'd2, 16'd3};
        tbl[3] = '{16'd4, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4};
`else
        tbl[0] = '{16'd1, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[1] = '{16'd2, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[2] = '{16'd3, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[3] = '{16'd4, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4};
`endif

        repeat (2) @(negedge clk);
        check_all_zero("por");
        rst = 1'b0;

        // Basic timing at DILATION=1 against fixed vectors.
        for (int i = 0; i < 4; i++) begin
            send(mk(tbl[i].lane), $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d ov", i), SAMPLE_W'(obs_ov1), SAMPLE_W'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d a0", i), if1.packed_a0, mk(tbl[i].e0));
            chk($sformatf("tbl%0d a1", i), if1.packed_a1, mk(tbl[i].e1));
            chk($sformatf("tbl%0d a2", i), if1.packed_a2, mk(tbl[i].e2));
            chk($sformatf("tbl%0d a3", i), if1.packed_a3, mk(tbl[i].e3));
        end

        // Dilation 2 with pointer wrap.
        do_reset();
        for (int v = 0; v < 10; v++) begin
            send(mk(16'(v)), $sformatf("dil%0d", v));
`ifndef TAP_ZERO_PAD_EN
            if (v == 6) begin
                chk("dil6 a0", if2.packed_a0, mk(16'd0));
                chk("dil6 a1", if2.packed_a1, mk(16'd2));
                chk("dil6 a2", if2.packed_a2, mk(16'd4));
                chk("dil6 a3", if2.packed_a3, mk(16'd6));
            end
            if (v == 9) begin
                chk("dil9 a0", if2.packed_a0, mk(16'd3));
                chk("dil9 a1", if2.packed_a1, mk(16'd5));
                chk("dil9 a2", if2.packed_a2, mk(16'd7));
                chk("dil9 a3", if2.packed_a3, mk(16'd9));
            end
`endif
        end

        // Overrun: second strobe lands in the gather cycle and is dropped.
        @(negedge clk);
        drv_data = mk(16'd7);
        in_v     = 1'b1;
        @(negedge clk);
        drv_data = mk(16'd8);
        hist.push_back(mk(16'd7));
        @(negedge clk);
        in_v    = 1'b0;
        exp_ovr = 1'b1;
        check_emit("ovr");
        chk("ovr a3 d0", if1.packed_a3, mk(16'd7));
        chk("ovr flag d0", SAMPLE_W'(if1.overrun), SAMPLE_W'(1));
        @(negedge clk);
        check_idle("ovr");
        send(mk(16'd11), "ovr_next");

        // Bit-exact signed extremes, channel 0 in the MSBs.
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < int'(D); c++)
                s[(int'(D) - 1 - c) * int'(W) +: W] = (((c + k) % 2) == 0) ? 16'h8000 : 16'h7FFF;
            send(s, $sformatf("sign%0d", k));
            chk($sformatf("sign%0d a3", k), if1.packed_a3, s);
            chk($sformatf("sign%0d ch0", k), SAMPLE_W'(if1.packed_a3[SAMPLE_W-1 -: W]),
                SAMPLE_W'((k == 0) ? 16'h8000 : 16'h7FFF));
        end

        // Random samples with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            send(s, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during the gather cycle cancels the pending pulse and restarts warm-up.
        @(negedge clk);
        drv_data = mk(16'h1234);
        in_v     = 1'b1;
        @(negedge clk);
        in_v = 1'b0;
        rst  = 1'b1;
        model_reset();
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        check_all_zero("midrst2");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(mk(16'(100 + i)), $sformatf("warm%0d", i));
`ifndef TAP_ZERO_PAD_EN
            chk($sformatf("warm%0d suppressed", i), SAMPLE_W'(obs_ov1), '0);
`endif
        end
        send(mk(16'd200), "warm3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
